nonce_result_fifo: RTL and testbench

Buffers golden nonces from the miner core so that a second hit arriving before software has read the first is never lost. It sits directly downstream of `fpgaminer_top`, in parallel with the header-loading bus slave. It samples the 33-bit `{found, nonce}` output every cycle and queues found nonces in a small FIFO. Software pops them through a byte-wide Avalon-MM slave port and can use an interrupt line when the FIFO is non-empty.

---
 rtl/miner_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/nonce_result_fifo.sv | 91 +++++++++
 tb/tb_nonce_result_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared types and register map for the miner result path.
package miner_pkg;
    localparam int NONCE_W = 32;
    typedef struct packed {
        logic               found;
        logic [NONCE_W-1:0] nonce;
    } nonce_result_t;
    localparam logic [3:0] NRF_ADDR_B0      = 4'd0;
    localparam logic [3:0] NRF_ADDR_STATUS  = 4'd4;
    localparam logic [3:0] NRF_ADDR_COUNT   = 4'd5;
    localparam logic [3:0] NRF_ADDR_DROPPED = 4'd6;
    localparam logic [3:0] NRF_ADDR_CTRL    = 4'd8;
    localparam logic [3:0] NRF_ADDR_FLUSH   = 4'd9;
    localparam int NRF_ST_EMPTY = 0;
    localparam int NRF_ST_FULL  = 1;
    localparam int NRF_ST_OVF   = 2;
    function automatic logic [7:0] nrf_byte(input logic [NONCE_W-1:0] n, input logic [1:0] i);
        return n[i*8 +: 8];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full/empty and flush.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d, do_push, do_pop;
    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d   = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = cnt_d == (AW+1)'(DEPTH);
        empty_d = cnt_d == '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/nonce_result_fifo.sv
// nonce_result_fifo: queues golden nonces for software readout over a byte-wide slave.
// Define NONCE_DEDUP_EN to collapse a held found level with an unchanged nonce into one entry.
module nonce_result_fifo
    import miner_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NONCE_W:0]     nonce_in,
    input  logic                 flush,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [3:0]           address,
    input  logic [7:0]           writedata,
    output logic [7:0]           readdata,
    output logic                 nonce_irq
);
    localparam int AW = $clog2(DEPTH);
    nonce_result_t      hit;
    logic               wr_en, pop_req, clr_req, flush_all, hit_ok, push, drop;
    logic [NONCE_W-1:0] head;
    logic [AW:0]        count;
    logic               full, empty, ovf_q, ovf_d;
    logic [7:0]         drop_q, drop_d, drop_base, status, reg_val, rd_q, rd_d;
    assign hit       = nonce_in;
    assign wr_en     = chipselect && write;
    assign pop_req   = wr_en && address == NRF_ADDR_CTRL && writedata[0];
    assign clr_req   = wr_en && address == NRF_ADDR_CTRL && writedata[1];
    assign flush_all = flush || (wr_en && address == NRF_ADDR_FLUSH && writedata[0]);
`ifdef NONCE_DEDUP_EN
    logic [NONCE_W-1:0] last_q;
    logic               prev_q;
    assign hit_ok = hit.found && (!prev_q || hit.nonce != last_q);
    always_ff @(posedge clk) begin
        if (reset || flush_all) begin
            last_q <= '0;
            prev_q <= 1'b0;
        end else begin
            prev_q <= hit.found;
            if (hit_ok) last_q <= hit.nonce;
        end
    end
`else
    assign hit_ok = hit.found;
`endif
    assign push = hit_ok && !flush_all;
    sync_fifo #(.W(NONCE_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_all),
        .push  (push),
        .pop   (pop_req),
        .din   (hit.nonce),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // a pop frees the slot a simultaneous push needs, so only an unpopped full push drops
    always_comb begin
        drop      = push && full && !pop_req;
        drop_base = clr_req ? 8'h00 : drop_q;
        drop_d    = drop_base + 8'(drop && drop_base != 8'hFF);
        ovf_d     = drop || (ovf_q && !clr_req);
        status    = '0;
        status[NRF_ST_EMPTY] = empty;
        status[NRF_ST_FULL]  = full;
        status[NRF_ST_OVF]   = ovf_q;
        reg_val   = address < NRF_ADDR_STATUS ? (empty ? 8'h00 : nrf_byte(head, address[1:0])) :
                    address == NRF_ADDR_STATUS  ? status :
                    address == NRF_ADDR_COUNT   ? 8'(count) :
                    address == NRF_ADDR_DROPPED ? drop_q : 8'h00;
        rd_d      = (chipselect && read) ? reg_val : rd_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
            rd_q   <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            rd_q   <= rd_d;
        end
    end
    assign readdata  = rd_q;
    assign nonce_irq = !empty;
    wire unused_ok = &{1'b0, writedata[7:2]};
endmodule

// File: tb/tb_nonce_result_fifo.sv
// tb_nonce_result_fifo: directed and random checks against a queue-based model.
module tb_nonce_result_fifo;
    localparam int DEPTH = 8;
`ifdef NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif
    logic        clk = 1'b0, reset, flush, chipselect, read, write, nonce_irq;
    logic [32:0] nonce_in;
    logic [3:0]  address;
    logic [7:0]  writedata, readdata;
    int          n_chk = 0, n_fail = 0;
    int unsigned q[$];
    bit          m_ovf, m_prev;
    int          m_drop;
    int unsigned m_last;
    always #5 clk = ~clk;
    nonce_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .nonce_in(nonce_in), .flush(flush),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .nonce_irq(nonce_irq)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] mreg(input int a);
        if (a < 4) return q.size() == 0 ? 8'h00 : 8'((q[0] >> (8 * a)) & 32'hFF);
        if (a == 4) return {5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
        if (a == 5) return 8'(q.size());
        if (a == 6) return 8'(m_drop);
        return 8'h00;
    endfunction
    task automatic model(input bit f, input int unsigned n, input bit pop, input bit clr, input bit fl);
        bit acc;
        if (fl) begin
            q.delete();
            m_prev = 1'b0;
            return;
        end
        acc = f && (!DEDUP || !m_prev || n != m_last);
        if (acc) m_last = n;
        m_prev = f;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (acc) begin
            if (q.size() == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end else q.push_back(n);
        end
    endtask
    task automatic idle_inputs();
        nonce_in = '0; flush = 0; chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
    endtask
    task automatic step(input bit f, input int unsigned n, input bit pop, input bit clr, input bit wfl, input bit pfl);
        nonce_in = {f, n[31:0]};
        flush    = pfl;
        if (pop || clr || wfl) begin
            chipselect = 1; write = 1;
            address    = wfl ? 4'd9 : 4'd8;
            writedata  = wfl ? 8'h01 : {6'b0, clr, pop};
        end
        model(f, n, pop, clr, wfl || pfl);
        @(posedge clk); #1;
        idle_inputs();
    endtask
    task automatic rd(input int a);
        logic [7:0] exp;
        exp = mreg(a);
        chipselect = 1; read = 1; address = 4'(a);
        model(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        idle_inputs();
        chk($sformatf("rd_addr%0d", a), readdata, exp);
    endtask
    task automatic check_all(input string tag);
        chk({tag, "_irq"}, nonce_irq, q.size() != 0);
        for (int a = 0; a < 7; a++) rd(a);
        rd(7);
        rd(15);
    endtask
    task automatic do_reset();
        reset = 1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 0;
        q.delete(); m_ovf = 0; m_drop = 0; m_prev = 0; m_last = 0;
    endtask
    task automatic head_word(input string tag, input int unsigned exp);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            rd(b);
            w = w | (32'(readdata) << (8 * b));
        end
        chk(tag, w, exp);
    endtask
    initial begin
        logic [7:0] held;
        do_reset();
        chk("reset_readdata", readdata, 8'h00);
        chk("reset_irq", nonce_irq, 1'b0);
        check_all("reset");
        rd(4); chk("reset_status", readdata, 8'h01);
        step(1, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("hit_irq", nonce_irq, 1'b1);
        rd(0); chk("byte0", readdata, 8'hEF);
        rd(1); chk("byte1", readdata, 8'hBE);
        rd(2); chk("byte2", readdata, 8'hAD);
        rd(3); chk("byte3", readdata, 8'hDE);
        rd(5); chk("count1", readdata, 8'd1);
        held = readdata;
        step(0, 0, 0, 0, 0, 0);
        chk("readdata_hold", readdata, held);
        step(0, 0, 1, 0, 0, 0);
        chk("pop_irq", nonce_irq, 1'b0);
        rd(4); chk("pop_status", readdata, 8'h01);
        step(0, 0, 1, 0, 0, 0);
        check_all("pop_empty");
        for (int i = 0; i < 9; i++) step(1, 32'h10 + i, 0, 0, 0, 0);
        rd(4); chk("ovf_status", readdata, 8'h06);
        rd(5); chk("ovf_count", readdata, 8'd8);
        rd(6); chk("ovf_dropped", readdata, 8'd1);
        check_all("full");
        for (int i = 0; i < 8; i++) begin
            head_word($sformatf("order%0d", i), 32'h10 + i);
            step(0, 0, 1, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0, 0);
        rd(4); chk("clr_status", readdata, 8'h01);
        check_all("cleared");
        for (int i = 0; i < 8; i++) step(1, 32'h20 + i, 0, 0, 0, 0);
        step(1, 32'h99, 1, 0, 0, 0);
        rd(5); chk("pushpop_count", readdata, 8'd8);
        rd(4); chk("pushpop_status", readdata, 8'h02);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
        head_word("last_99", 32'h99);
        step(0, 0, 1, 0, 0, 0);
        check_all("drained");
        for (int i = 0; i < 4; i++) step(1, 32'h42, 0, 0, 0, 0);
        rd(5); chk("held_hit_count", readdata, DEDUP ? 8'd1 : 8'd4);
        check_all("held");
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 32'h30 + i, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        rd(5); chk("pre_flush_count", readdata, 8'd3);
        step(1, 32'h55, 0, 0, 0, 1);
        rd(5); chk("flush_count", readdata, 8'd0);
        rd(4); chk("flush_status", readdata, 8'h05);
        check_all("flushed");
        step(1, 32'h61, 0, 0, 0, 0);
        step(1, 32'h62, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check_all("reg_flush");
        for (int i = 0; i < 500; i++) begin
            int r;
            bit f, p, c;
            r = $urandom_range(0, 19);
            f = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 2) == 0;
            c = $urandom_range(0, 30) == 0;
            if (r == 0) step(f, $urandom_range(0, 3), 0, 0, 0, 1);
            else if (r == 1) step(f, $urandom_range(0, 3), 0, 0, 1, 0);
            else step(f, $urandom_range(0, 3), p, c, 0, 0);
            if (i % 25 == 24) check_all($sformatf("rand%0d", i));
        end
        step(1, 32'h77, 0, 0, 0, 0);
        do_reset();
        chk("midreset_readdata", readdata, 8'h00);
        chk("midreset_irq", nonce_irq, 1'b0);
        check_all("midreset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
